// File: rtl/data_sync_pkg.sv
// Shared definitions for the data-sync bus: launcher FSM states and default
// bus geometry used by both the launcher and the destination synchronizer.
package data_sync_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;
    localparam logic [1:0] ST_ACKED = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        REQ   = ST_REQ,
        ACKED = ST_ACKED
    } state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer bringing an asynchronous level into clk.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through STAGES flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/data_sync_launcher.sv
// Source-side launcher for the data-sync bus: captures a word, presents it on
// async_bus, raises bus_en after a setup gap and holds everything stable through
// a four-phase req/ack handshake with the destination domain.
module data_sync_launcher
    import data_sync_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int STAGES    = DEFAULT_STAGES,
    parameter int SETUP_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] async_bus,
    output logic             bus_en,
    input  logic             ack_async,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = $clog2(SETUP_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETUP_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] setup_cnt;
    logic [CNT_W-1:0] setup_cnt_d;
    logic             ack_s;
    logic             load_word;
    logic             bus_en_d;
    logic             tx_ready_d;
    logic             busy_d;
    logic             done_d;

    bit_sync #(
        .STAGES (STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_async),
        .q   (ack_s)
    );

    // State and setup-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            setup_cnt <= '0;
        end else begin
            state     <= next_state;
            setup_cnt <= setup_cnt_d;
        end
    end

    // Handshake sequencing; a stale ack in SETUP keeps reloading the setup count
    always_comb begin
        next_state  = state;
        setup_cnt_d = setup_cnt;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    next_state  = SETUP;
                    setup_cnt_d = CNT_LOAD;
                end
            end
            SETUP: begin
                if (ack_s) begin
                    setup_cnt_d = CNT_LOAD;
                end else if (setup_cnt == '0) begin
                    next_state = REQ;
                end else begin
                    setup_cnt_d = setup_cnt - CNT_W'(1);
                end
            end
            REQ: begin
                if (ack_s) begin
                    next_state = ACKED;
                end
            end
            ACKED: begin
                if (!ack_s) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the upcoming state
    always_comb begin
        load_word  = (state == IDLE) && tx_valid;
        bus_en_d   = (next_state == REQ);
        tx_ready_d = (next_state == IDLE);
        busy_d     = (next_state != IDLE);
        done_d     = (state == ACKED) && (next_state == IDLE);
    end

    // Registered outputs so nothing asynchronous reaches the ports combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            async_bus <= '0;
            bus_en    <= 1'b0;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (load_word) begin
                async_bus <= tx_data;
            end
            bus_en   <= bus_en_d;
            tx_ready <= tx_ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_data_sync_launcher.sv
// Directed testbench for data_sync_launcher with a delayed-echo ack model and a
// receive-side monitor that captures each word on the rising edge of bus_en.
module tb_data_sync_launcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] async_bus;
    logic       bus_en;
    logic       ack_async;
    logic       busy;
    logic       done;

    logic [2:0] ack_pipe;
    logic       ack_force;

    int test_count = 0;
    int fail_count = 0;

    logic [7:0] rx_q[$];
    logic       bus_en_prev = 1'b0;
    logic [7:0] bus_prev = 8'h00;
    int         bus_change_errs = 0;
    int         done_pulses = 0;

    logic [7:0] words[16];

    data_sync_launcher #(
        .WIDTH     (8),
        .STAGES    (2),
        .SETUP_CYC (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .async_bus (async_bus),
        .bus_en    (bus_en),
        .ack_async (ack_async),
        .busy      (busy),
        .done      (done)
    );

    // 20 ns source clock
    always #10 clk = ~clk;

    // Destination model: ack is bus_en delayed three clocks, optionally forced high
    always @(posedge clk) ack_pipe <= {ack_pipe[1:0], bus_en};
    assign ack_async = ack_force | ack_pipe[2];

    // Receive monitor: capture on bus_en rise, flag data changes while bus_en held, count done
    always @(negedge clk) begin
        if (bus_en && !bus_en_prev) rx_q.push_back(async_bus);
        if (bus_en && bus_en_prev && (async_bus !== bus_prev)) bus_change_errs++;
        if (done) done_pulses++;
        bus_en_prev = bus_en;
        bus_prev    = async_bus;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic valid);
        @(negedge clk);
        tx_data  = data;
        tx_valid = valid;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_output({tag, " done seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_bus_en(input string tag);
        int n = 0;
        while (bus_en !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check_output({tag, " bus_en rose"}, 32'(bus_en), 32'd1);
    endtask

    // Offer a word with tx_valid held until the launcher accepts it
    task automatic send_word(input logic [7:0] data, input string tag);
        int n = 0;
        apply_stimulus(data, 1'b1);
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) check_output({tag, " accept timeout"}, 32'd0, 32'd1);
        step();
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        ack_force = 1'b0;
        ack_pipe  = 3'b000;

        // Reset asserted mid-cycle takes effect at once
        #5;
        rst = 1'b1;
        #1;
        check_output("reset async_bus", 32'(async_bus), 32'h00);
        check_output("reset bus_en",    32'(bus_en),    32'd0);
        check_output("reset tx_ready",  32'(tx_ready),  32'd1);
        check_output("reset busy",      32'(busy),      32'd0);
        check_output("reset done",      32'(done),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single word 0xEC with exact handshake timing
        rx_q.delete();
        apply_stimulus(8'hEC, 1'b1);
        step();
        tx_valid = 1'b0;
        check_output("single async_bus at accept", 32'(async_bus), 32'hEC);
        check_output("single busy at accept",      32'(busy),      32'd1);
        check_output("single tx_ready at accept",  32'(tx_ready),  32'd0);
        check_output("single bus_en in setup",     32'(bus_en),    32'd0);
        step();
        check_output("single bus_en after setup",  32'(bus_en),    32'd1);
        n = 0;
        while (bus_en === 1'b1 && n < 50) begin
            step();
            n++;
        end
        check_output("single bus_en high cycles",  32'(n),         32'd6);
        check_output("single async_bus held",      32'(async_bus), 32'hEC);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check_output("single cycles to done",      32'(n),         32'd6);
        check_output("single tx_ready with done",  32'(tx_ready),  32'd1);
        check_output("single busy with done",      32'(busy),      32'd0);
        step();
        check_output("single done one cycle",      32'(done),      32'd0);
        check_output("single rx count",            32'(rx_q.size()), 32'd1);
        check_output("single rx word",             (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD_BEEF, 32'hEC);

        // Stale ack: ack held high in idle is ignored, then blocks bus_en in setup
        rx_q.delete();
        @(negedge clk);
        ack_force = 1'b1;
        repeat (4) step();
        check_output("stale idle tx_ready", 32'(tx_ready), 32'd1);
        check_output("stale idle busy",     32'(busy),     32'd0);
        apply_stimulus(8'h5A, 1'b1);
        step();
        tx_valid = 1'b0;
        repeat (5) step();
        check_output("stale bus_en held low", 32'(bus_en),    32'd0);
        check_output("stale busy",            32'(busy),      32'd1);
        check_output("stale async_bus",       32'(async_bus), 32'h5A);
        @(negedge clk);
        ack_force = 1'b0;
        n = 0;
        while (bus_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_output("stale cycles to bus_en", 32'(n), 32'd3);
        wait_done("stale");
        check_output("stale rx count", 32'(rx_q.size()), 32'd1);
        check_output("stale rx word",  (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD_BEEF, 32'h5A);

        // Busy rejection: 0x33 offered during REQ must wait its turn
        rx_q.delete();
        apply_stimulus(8'h77, 1'b1);
        step();
        tx_valid = 1'b0;
        wait_bus_en("reject");
        apply_stimulus(8'h33, 1'b1);
        repeat (3) step();
        check_output("reject tx_ready",  32'(tx_ready),  32'd0);
        check_output("reject async_bus", 32'(async_bus), 32'h77);
        check_output("reject bus_en",    32'(bus_en),    32'd1);
        wait_done("reject first");
        step();
        tx_valid = 1'b0;
        check_output("reject late accept", 32'(async_bus), 32'h33);
        check_output("reject late busy",   32'(busy),      32'd1);
        wait_done("reject second");
        check_output("reject rx count", 32'(rx_q.size()), 32'd2);
        check_output("reject rx word0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD_BEEF, 32'h77);
        check_output("reject rx word1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hDEAD_BEEF, 32'h33);

        // Back-to-back: 16 random words with tx_valid held throughout
        for (int i = 0; i < 16; i++) words[i] = 8'($urandom_range(0, 255));
        step();
        rx_q.delete();
        done_pulses = 0;
        for (int i = 0; i < 16; i++) send_word(words[i], $sformatf("b2b %0d", i));
        tx_valid = 1'b0;
        wait_done("b2b");
        step();
        check_output("b2b done pulses", 32'(done_pulses), 32'd16);
        check_output("b2b rx count",    32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("b2b word %0d", i),
                         (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_BEEF, 32'(words[i]));
        end

        // Reset in REQ drops the word; the next one transfers cleanly
        apply_stimulus(8'hA5, 1'b1);
        step();
        tx_valid = 1'b0;
        wait_bus_en("midreset");
        @(negedge clk);
        #5;
        rst = 1'b1;
        #1;
        check_output("midreset bus_en",    32'(bus_en),    32'd0);
        check_output("midreset async_bus", 32'(async_bus), 32'h00);
        check_output("midreset tx_ready",  32'(tx_ready),  32'd1);
        check_output("midreset busy",      32'(busy),      32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        done_pulses = 0;
        step();
        check_output("midreset idle tx_ready", 32'(tx_ready), 32'd1);
        check_output("midreset idle busy",     32'(busy),     32'd0);
        apply_stimulus(8'h3C, 1'b1);
        step();
        tx_valid = 1'b0;
        wait_done("midreset next");
        step();
        check_output("midreset done pulses", 32'(done_pulses), 32'd1);
        check_output("midreset rx count",    32'(rx_q.size()), 32'd1);
        check_output("midreset rx word",     (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD_BEEF, 32'h3C);

        check_output("bus stable while bus_en", 32'(bus_change_errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
